// File: rtl/ahb_decoder_mux_if.sv
// AHB-Lite decoder/mux bus bundle: master address phase, per-slave responses,
// and the muxed response returned to the master.
interface ahb_decoder_mux_if #(
  parameter int unsigned NSLAVE = 4
);
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic [NSLAVE-1:0]    HSEL;
  logic [NSLAVE*32-1:0] HRDATA_S;
  logic [NSLAVE-1:0]    HREADYOUT_S;
  logic [NSLAVE-1:0]    HRESP_S;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL, HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL, HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase response mux and built-in default slave
// that returns the two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.
module ahb_decoder_mux #(
  parameter int unsigned          NSLAVE = 4,
  parameter logic [NSLAVE*32-1:0] BASE   = {32'h2000_3000, 32'h2020_0000,
                                            32'h0002_0000, 32'h0000_0000},
  parameter logic [NSLAVE*32-1:0] MASK   = {32'hFFFF_FF00, 32'hFFFF_FFF0,
                                            32'hFFFE_0000, 32'hFFFF_0000}
) (
  input  logic                   clk,
  input  logic                   reset,
  ahb_decoder_mux_if.slave       bus,
  output logic [15:0]            DECERR_CNT,
  output logic [31:0]            DECERR_ADDR
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t            state, state_next;
  logic [NSLAVE-1:0] sel;
  logic [NSLAVE-1:0] dsel;
  logic              hit_any;
  logic              active;
  logic              err_start;
  logic [31:0]       rdata;
  logic              ready;
  logic              resp;

  // Lowest-index region wins when regions overlap.
  always_comb begin
    sel     = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (!hit_any &&
          ((bus.HADDR & MASK[i*32 +: 32]) == (BASE[i*32 +: 32] & MASK[i*32 +: 32]))) begin
        sel[i]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  assign bus.HSEL  = sel;
  assign active    = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  // The default slave's request bit is folded into the FSM: ERR1 is entered
  // exactly on the edge that would load it.
  assign err_start = ready && !hit_any && active;

  always_comb begin
    rdata = '0;
    ready = 1'b1;
    resp  = 1'b0;
    if (dsel == '0) begin
      unique case (state)
        S_ERR1: begin
          ready = 1'b0;
          resp  = 1'b1;
        end
        S_ERR2:  resp = 1'b1;
        default: ;
      endcase
    end else begin
      for (int unsigned i = 0; i < NSLAVE; i++) begin
        if (dsel[i]) begin
          rdata = bus.HRDATA_S[i*32 +: 32];
          ready = bus.HREADYOUT_S[i];
          resp  = bus.HRESP_S[i];
        end
      end
    end
  end

  assign bus.HRDATA = rdata;
  assign bus.HREADY = ready;
  assign bus.HRESP  = resp;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (err_start) state_next = S_ERR1;
      S_ERR1:  state_next = S_ERR2;
      S_ERR2:  state_next = err_start ? S_ERR1 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel        <= '0;
      DECERR_CNT  <= '0;
      DECERR_ADDR <= '0;
    end else begin
      if (ready) begin
        dsel <= sel;
      end
      if (err_start) begin
        DECERR_ADDR <= bus.HADDR;
        if (DECERR_CNT != '1) begin
          DECERR_CNT <= DECERR_CNT + 16'd1;
        end
      end
    end
  end

endmodule
